equiv_response_checker: RTL and testbench

- Response-side counterpart to the stimulus driver in the equivalence-checking benches.
- Every cycle it samples the 136-bit output bus of the golden model and of the synthesized netlist. It compares the two, counts mismatches and records the first failing cycle and bit.
- It also compresses the netlist output stream into a 32-bit MISR signature, so long runs can be checked against a stored value.
- It sits in the testbench between the two `top` instances and the result-reporting logic, and replaces per-cycle `$strobe` dumps.

---
 rtl/equiv_response_checker.sv | 138 +++++++++++++
 tb/tb_equiv_response_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_response_checker.sv
// equiv_response_checker
//   Compares the golden-model and netlist response buses sample by sample,
//   counts mismatching samples, records the first failing sample index and
//   its lowest differing bit, and compresses the netlist stream into a
//   32-bit MISR signature.
//
// Ports:
//   clk               sample clock, rising edge
//   rst_n             asynchronous active-low reset
//   start             one-cycle pulse that begins a run (IDLE/DONE only)
//   valid             y_ref/y_dut pair is sampled this cycle (RUN only)
//   y_ref, y_dut      golden and netlist response buses
//   busy              high while a run is in progress
//   done              high once NUM_VECTORS samples have been accepted
//   pass              in DONE: no mismatching sample; 0 otherwise
//   mismatch_count    mismatching samples, saturating at 255
//   first_fail_cycle  0-based index of the first mismatching sample, FF if none
//   first_fail_bit    lowest differing bit of that sample, FF if none
//   signature         MISR over y_dut
module equiv_response_checker #(
    parameter int unsigned WIDTH       = 136,
    parameter int unsigned NUM_VECTORS = 21,
    parameter logic [31:0] SIG_SEED    = 32'hFFFFFFFF,
    parameter logic [31:0] SIG_POLY    = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       mismatch_count,
    output logic [7:0]       first_fail_cycle,
    output logic [7:0]       first_fail_bit,
    output logic [31:0]      signature
);

    localparam int unsigned NCHUNK = (WIDTH + 31) / 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state;
    logic [7:0]              count;

    logic                    mismatch;
    logic                    found;
    logic [7:0]              diff_bit;
    logic [NCHUNK*32-1:0]    padded;
    logic [31:0]             fold;
    logic [31:0]             sig_next;
    logic [7:0]              mc_next;
    logic                    last;

    always_comb begin
        // Case inequality so that X/Z on either bus is reported as a mismatch.
        mismatch = (y_ref !== y_dut);

        found    = 1'b0;
        diff_bit = 8'hFF;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && (y_ref[i] !== y_dut[i])) begin
                diff_bit = 8'(i);
                found    = 1'b1;
            end
        end

        // Top chunk is zero-padded before folding.
        padded            = '0;
        padded[WIDTH-1:0] = y_dut;
        fold              = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            fold = fold ^ padded[c*32 +: 32];
        end

        sig_next = {signature[30:0], 1'b0} ^ (signature[31] ? SIG_POLY : '0) ^ fold;

        mc_next = mismatch_count;
        if (mismatch && (mismatch_count != 8'hFF)) begin
            mc_next = mismatch_count + 8'd1;
        end

        last = (count == 8'(NUM_VECTORS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            count            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_cycle <= '1;
            first_fail_bit   <= '1;
            signature        <= SIG_SEED;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // valid is ignored here, even in the start cycle.
                    if (start) begin
                        state            <= S_RUN;
                        count            <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_count   <= '0;
                        first_fail_cycle <= '1;
                        first_fail_bit   <= '1;
                        signature        <= SIG_SEED;
                    end
                end
                S_RUN: begin
                    if (valid) begin
                        count          <= count + 8'd1;
                        signature      <= sig_next;
                        mismatch_count <= mc_next;
                        // A zero count before this sample marks it as the first failure.
                        if (mismatch && (mismatch_count == 8'd0)) begin
                            first_fail_cycle <= count;
                            first_fail_bit   <= diff_bit;
                        end
                        if (last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mc_next == 8'd0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_response_checker.sv
// Bench for equiv_response_checker: a scoreboard of expected run results,
// computed from an independent bit-serial model while stimulus is driven,
// compared when the DUT reports done.
module tb_equiv_response_checker;

    localparam logic [31:0] SEED = 32'hFFFFFFFF;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic         clk = 1'b0;
    logic         rst_n, start, valid, start2, valid2;
    logic [135:0] y_ref, y_dut;

    logic         busy, done, pass;
    logic [7:0]   mc, ffc, ffb;
    logic [31:0]  sig;
    logic         busy2, done2, pass2;
    logic [7:0]   mc2, ffc2, ffb2;
    logic [31:0]  sig2;

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  ffc;
        logic [7:0]  ffb;
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [135:0] sref [0:255];
    logic [135:0] sdut [0:255];

    always #5 clk = ~clk;

    equiv_response_checker #(.WIDTH(136), .NUM_VECTORS(21), .SIG_SEED(SEED), .SIG_POLY(POLY)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .y_ref(y_ref), .y_dut(y_dut),
        .busy(busy), .done(done), .pass(pass), .mismatch_count(mc),
        .first_fail_cycle(ffc), .first_fail_bit(ffb), .signature(sig)
    );

    equiv_response_checker #(.WIDTH(136), .NUM_VECTORS(255), .SIG_SEED(SEED), .SIG_POLY(POLY)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .valid(valid2), .y_ref(y_ref), .y_dut(y_dut),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_count(mc2),
        .first_fail_cycle(ffc2), .first_fail_bit(ffb2), .signature(sig2)
    );

    // Bit-serial reference: bit b of y_dut lands in fold bit b%32.
    task automatic model_run(input int n, output exp_t e);
        logic [31:0] s;
        logic [31:0] f;
        s = SEED; e.mc = 8'd0; e.ffc = 8'hFF; e.ffb = 8'hFF;
        for (int k = 0; k < n; k++) begin
            f = '0;
            for (int b = 0; b < 136; b++) f[b % 32] = f[b % 32] ^ sdut[k][b];
            s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
            if (sref[k] !== sdut[k]) begin
                if (e.mc == 8'd0) begin
                    e.ffc = 8'(k);
                    for (int b = 0; b < 136; b++) begin
                        if (sref[k][b] !== sdut[k][b]) begin
                            e.ffb = 8'(b);
                            break;
                        end
                    end
                end
                if (e.mc != 8'hFF) e.mc = e.mc + 8'd1;
            end
        end
        e.sig  = s;
        e.pass = (e.mc == 8'd0);
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 256; k++) begin
            if (mode == 1 || k == 0) sref[k] = '0;
            else if (k == 1)         sref[k] = '1;
            else                     sref[k] = {17{8'(k)}};
            sdut[k] = sref[k];
        end
    endtask

    task automatic do_start(input bit with_valid);
        @(negedge clk);
        start = 1'b1; valid = with_valid;
        y_ref = '0; y_dut = 136'h5;
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
    endtask

    task automatic drive_samples(input int first, input int n, input bit stall);
        for (int k = first; k < first + n; k++) begin
            if (stall) begin
                @(negedge clk);
                valid = 1'b0; y_dut = ~sdut[k];
            end
            @(negedge clk);
            valid = 1'b1; y_ref = sref[k]; y_dut = sdut[k];
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue required one entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (mc !== e.mc)    begin errors++; $display("FAIL %s count: got %0d required %0d", name, mc, e.mc); end
        checks++;
        if (ffc !== e.ffc)  begin errors++; $display("FAIL %s first_cycle: got %0h required %0h", name, ffc, e.ffc); end
        checks++;
        if (ffb !== e.ffb)  begin errors++; $display("FAIL %s first_bit: got %0h required %0h", name, ffb, e.ffb); end
        checks++;
        if (sig !== e.sig)  begin errors++; $display("FAIL %s signature: got %h required %h", name, sig, e.sig); end
        checks++;
        if (pass !== e.pass) begin errors++; $display("FAIL %s pass: got %b required %b", name, pass, e.pass); end
    endtask

    // Full run of 21 samples; done must rise exactly one cycle after the last.
    task automatic full_run(input string name, input bit stall, input bit start_valid);
        exp_t e;
        model_run(21, e);
        sb.push_back(e);
        do_start(start_valid);
        drive_samples(0, 20, stall);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s early_done: got done=%b busy=%b required done=0 busy=1", name, done, busy);
        end
        drive_samples(20, 1, stall);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_latency: got done=%b busy=%b required done=1 busy=0", name, done, busy);
        end
        pop_check(name);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({busy, done, pass, mc, ffc, ffb, sig} !== {3'b000, 8'h00, 8'hFF, 8'hFF, SEED}) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b pass=%b mc=%0d ffc=%h ffb=%h sig=%h required 0 0 0 0 ff ff %h",
                     name, busy, done, pass, mc, ffc, ffb, sig, SEED);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; start2 = 1'b0; valid2 = 1'b0;
        y_ref = '0; y_dut = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_identical();
        fill(0);
        full_run("identical", 1'b0, 1'b0);
        checks++;
        if (pass !== 1'b1 || mc !== 8'd0 || ffc !== 8'hFF || ffb !== 8'hFF) begin
            errors++; $display("FAIL identical_const: got pass=%b mc=%0d ffc=%h ffb=%h required 1 0 ff ff", pass, mc, ffc, ffb);
        end
        // Outputs hold in DONE while valid toggles.
        @(negedge clk); valid = 1'b1; y_dut = ~y_ref;
        @(negedge clk); valid = 1'b0;
        checks++;
        if (done !== 1'b1 || mc !== 8'd0) begin
            errors++; $display("FAIL done_hold: got done=%b mc=%0d required 1 0", done, mc);
        end
    endtask

    task automatic test_single_corruption();
        fill(0);
        sdut[7] = sref[7] ^ (136'h1 << 37);
        full_run("corrupt", 1'b0, 1'b0);
        checks++;
        if (mc !== 8'd1 || ffc !== 8'd7 || ffb !== 8'd37 || pass !== 1'b0) begin
            errors++; $display("FAIL corrupt_const: got mc=%0d ffc=%0d ffb=%0d pass=%b required 1 7 37 0", mc, ffc, ffb, pass);
        end
    endtask

    task automatic test_stalls();
        fill(0);
        full_run("stall", 1'b1, 1'b0);
    endtask

    task automatic test_misr();
        logic [31:0] first_sig;
        fill(1);
        full_run("misr_zero", 1'b0, 1'b0);
        first_sig = sig;
        sdut[0][0] = 1'b1;
        full_run("misr_flip", 1'b0, 1'b0);
        checks++;
        if (sig === first_sig) begin
            errors++; $display("FAIL misr_differs: got %h required a value other than %h", sig, first_sig);
        end
    endtask

    // Restart from DONE with valid high in the start cycle: that sample is dropped.
    task automatic test_back_to_back();
        fill(0);
        full_run("b2b_start_valid", 1'b0, 1'b1);
        // start during RUN must not restart the run.
        fill(0);
        sdut[2] = ~sref[2];
        do_start(1'b0);
        drive_samples(0, 5, 1'b0);
        @(negedge clk); valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (mc !== 8'd1 || ffc !== 8'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL start_in_run: got mc=%0d ffc=%0d busy=%b required 1 2 1", mc, ffc, busy);
        end
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        fill(0);
        sdut[3] = sref[3] ^ 136'h100;
        do_start(1'b0);
        drive_samples(0, 11, 1'b0);
        @(negedge clk); valid = 1'b0;
        checks++;
        if (mc !== 8'd1 || ffc !== 8'd3 || ffb !== 8'd8) begin
            errors++; $display("FAIL midrun_state: got mc=%0d ffc=%0d ffb=%0d required 1 3 8", mc, ffc, ffb);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrun_reset");
        @(negedge clk); rst_n = 1'b1;
        fill(0);
        full_run("after_reset", 1'b0, 1'b0);
        checks++;
        if (pass !== 1'b1) begin
            errors++; $display("FAIL after_reset_pass: got %b required 1", pass);
        end
    endtask

    task automatic test_x_handling();
        exp_t e;
        fill(1);
        sref[0][135] = 1'b1;
        sdut[0][135] = 1'bx;
        model_run(21, e);
        do_start(1'b0);
        drive_samples(0, 21, 1'b0);
        @(negedge clk); valid = 1'b0;
        checks++;
        if (done !== 1'b1 || ffc !== 8'd0 || ffb !== 8'd135 || mc !== 8'd1 || pass !== 1'b0) begin
            errors++; $display("FAIL x_bit: got done=%b ffc=%0d ffb=%0d mc=%0d pass=%b required 1 0 135 1 0",
                               done, ffc, ffb, mc, pass);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            valid2 = 1'b1; y_ref = '0; y_dut = 136'(k + 1);
        end
        @(negedge clk); valid2 = 1'b0;
        checks++;
        if (done2 !== 1'b1 || mc2 !== 8'd255 || ffc2 !== 8'd0 || ffb2 !== 8'd0 || pass2 !== 1'b0) begin
            errors++; $display("FAIL saturation: got done=%b mc=%0d ffc=%0d ffb=%0d pass=%b required 1 255 0 0 0",
                               done2, mc2, ffc2, ffb2, pass2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identical();
        test_single_corruption();
        test_stalls();
        test_misr();
        test_back_to_back();
        test_reset_midrun();
        test_x_handling();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
